// File: rtl/ddr5_cmd_sequencer_pkg.sv
// Shared types, state encoding and default DDR5 timing for the command sequencer.
// Optional open-page behaviour is selected with the OPEN_PAGE_EN macro.
package ddr5_cmd_sequencer_pkg;

   typedef enum logic [3:0] {
      CMD_NOP  = 4'd0,
      CMD_ACT0 = 4'd1,
      CMD_ACT1 = 4'd2,
      CMD_RD0  = 4'd3,
      CMD_RD1  = 4'd4,
      CMD_WR0  = 4'd5,
      CMD_WR1  = 4'd6,
      CMD_PRE  = 4'd7,
      CMD_REF  = 4'd8
   } cmd_e;

   typedef struct packed {
      logic        op;
      logic [2:0]  bg;
      logic [1:0]  bank;
      logic [15:0] row;
      logic [9:0]  col;
   } req_t;

   typedef logic [3:0] seq_state_t;

   localparam seq_state_t S_IDLE     = 4'd0;
   localparam seq_state_t S_ACT0     = 4'd1;
   localparam seq_state_t S_ACT1     = 4'd2;
   localparam seq_state_t S_WAIT_RCD = 4'd3;
   localparam seq_state_t S_COL0     = 4'd4;
   localparam seq_state_t S_COL1     = 4'd5;
   localparam seq_state_t S_WAIT_COL = 4'd6;
   localparam seq_state_t S_PRE      = 4'd7;
   localparam seq_state_t S_WAIT_RP  = 4'd8;
   localparam seq_state_t S_REF      = 4'd9;
   localparam seq_state_t S_WAIT_RFC = 4'd10;

   localparam int unsigned DEF_T_RCD   = 39;
   localparam int unsigned DEF_T_CL    = 40;
   localparam int unsigned DEF_T_CWL   = 38;
   localparam int unsigned DEF_T_WR    = 72;
   localparam int unsigned DEF_T_BURST = 8;
   localparam int unsigned DEF_T_RP    = 39;
   localparam int unsigned DEF_T_REFI  = 9360;
   localparam int unsigned DEF_T_RFC   = 708;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ddr5_cmd_sequencer_timer.sv
// Down-counter with synchronous load; expired while the count sits at zero.
module ddr5_timer #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_expired
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_count <= RESET_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - ONE;
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/ddr5_cmd_sequencer.sv
// DDR5 command sequencer: request -> ACT -> RD/WR -> PRE with periodic REF insertion.
// Define OPEN_PAGE_EN to keep rows open between requests (default build is closed-page).
module ddr5_cmd_sequencer
   import ddr5_cmd_sequencer_pkg::*;
#(
   parameter int unsigned T_RCD   = DEF_T_RCD,
   parameter int unsigned T_CL    = DEF_T_CL,
   parameter int unsigned T_CWL   = DEF_T_CWL,
   parameter int unsigned T_WR    = DEF_T_WR,
   parameter int unsigned T_BURST = DEF_T_BURST,
   parameter int unsigned T_RP    = DEF_T_RP,
   parameter int unsigned T_REFI  = DEF_T_REFI,
   parameter int unsigned T_RFC   = DEF_T_RFC
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_op,
   input  logic [2:0]  i_req_bg,
   input  logic [1:0]  i_req_bank,
   input  logic [15:0] i_req_row,
   input  logic [9:0]  i_req_col,
   output logic        o_cmd_valid,
   output logic [3:0]  o_cmd,
   output logic [2:0]  o_cmd_bg,
   output logic [1:0]  o_cmd_bank,
   output logic [15:0] o_cmd_addr,
   output logic        o_done,
   output logic        o_ref_overrun
);

   localparam int unsigned T_RD_PRE = T_CL + T_BURST;
   localparam int unsigned T_WR_PRE = T_CWL + T_BURST + T_WR;
   localparam int unsigned T_MAX    = max_u(max_u(max_u(T_RCD, T_RD_PRE), max_u(T_WR_PRE, T_RP)),
                                            max_u(T_REFI, T_RFC));
   localparam int unsigned CW       = $clog2(T_MAX + 1);

   // Loaded on the issuing cycle; the successor issues the cycle after the count reaches zero.
   localparam logic [CW-1:0] LD_RCD  = CW'(T_RCD - 2);
   localparam logic [CW-1:0] LD_RD   = CW'(T_RD_PRE - 2);
   localparam logic [CW-1:0] LD_WR   = CW'(T_WR_PRE - 2);
   localparam logic [CW-1:0] LD_RP   = CW'(T_RP - 2);
   localparam logic [CW-1:0] LD_RFC  = CW'(T_RFC - 2);
   localparam logic [CW-1:0] LD_REFI = CW'(T_REFI - 1);

   seq_state_t    r_state, w_state_nxt;
   req_t          r_req;
   logic          r_ref_pending, r_ref_overrun;
   logic          w_accept, w_ref_issue;
   logic          w_wait_load, w_wait_exp, w_refi_exp;
   logic [CW-1:0] w_wait_val;
   logic [2:0]    w_pre_bg;
   logic [1:0]    w_pre_bank;

   assign o_req_ready   = (r_state == S_IDLE) & !r_ref_pending;
   assign w_accept      = o_req_ready & i_req_valid;
   assign w_ref_issue   = (r_state == S_REF);
   assign o_done        = (r_state == S_COL1);
   assign o_ref_overrun = r_ref_overrun;

`ifdef OPEN_PAGE_EN
   logic        r_open, r_have_req;
   logic [2:0]  r_open_bg;
   logic [1:0]  r_open_bank;
   logic [15:0] r_open_row;
   logic        w_hit;

   assign w_hit      = r_open & (r_open_bg == i_req_bg) & (r_open_bank == i_req_bank) &
                       (r_open_row == i_req_row);
   assign w_pre_bg   = r_open_bg;
   assign w_pre_bank = r_open_bank;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_open      <= 1'b0;
         r_have_req  <= 1'b0;
         r_open_bg   <= '0;
         r_open_bank <= '0;
         r_open_row  <= '0;
      end else begin
         if (w_accept) r_have_req <= r_open & !w_hit;
         else if (r_state == S_ACT0) r_have_req <= 1'b0;
         if (r_state == S_ACT0) begin
            r_open      <= 1'b1;
            r_open_bg   <= r_req.bg;
            r_open_bank <= r_req.bank;
            r_open_row  <= r_req.row;
         end else if (r_state == S_PRE) begin
            r_open <= 1'b0;
         end
      end
   end
`else
   assign w_pre_bg   = r_req.bg;
   assign w_pre_bank = r_req.bank;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
`ifdef OPEN_PAGE_EN
            if (r_ref_pending)    w_state_nxt = r_open ? S_PRE : S_REF;
            else if (i_req_valid) w_state_nxt = w_hit ? S_COL0 : (r_open ? S_PRE : S_ACT0);
`else
            if (r_ref_pending)    w_state_nxt = S_REF;
            else if (i_req_valid) w_state_nxt = S_ACT0;
`endif
         end
         S_ACT0:     w_state_nxt = S_ACT1;
         S_ACT1:     w_state_nxt = S_WAIT_RCD;
         S_WAIT_RCD: if (w_wait_exp) w_state_nxt = S_COL0;
         S_COL0:     w_state_nxt = S_COL1;
         S_COL1:     w_state_nxt = S_WAIT_COL;
`ifdef OPEN_PAGE_EN
         S_WAIT_COL: if (w_wait_exp) w_state_nxt = S_IDLE;
         S_WAIT_RP: begin
            if (w_wait_exp) begin
               if (r_have_req)         w_state_nxt = S_ACT0;
               else if (r_ref_pending) w_state_nxt = S_REF;
               else                    w_state_nxt = S_IDLE;
            end
         end
`else
         S_WAIT_COL: if (w_wait_exp) w_state_nxt = S_PRE;
         S_WAIT_RP:  if (w_wait_exp) w_state_nxt = S_IDLE;
`endif
         S_PRE:      w_state_nxt = S_WAIT_RP;
         S_REF:      w_state_nxt = S_WAIT_RFC;
         S_WAIT_RFC: if (w_wait_exp) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_wait_load = 1'b1;
      w_wait_val  = '0;
      case (r_state)
         S_ACT0:  w_wait_val = LD_RCD;
         S_COL0:  w_wait_val = r_req.op ? LD_WR : LD_RD;
         S_PRE:   w_wait_val = LD_RP;
         S_REF:   w_wait_val = LD_RFC;
         default: w_wait_load = 1'b0;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_req         <= '0;
         r_ref_pending <= 1'b0;
         r_ref_overrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_req <= {i_req_op, i_req_bg, i_req_bank, i_req_row, i_req_col};
         r_ref_pending <= w_refi_exp | (r_ref_pending & !w_ref_issue);
         if (w_refi_exp & r_ref_pending & !w_ref_issue) r_ref_overrun <= 1'b1;
      end
   end

   always_comb begin
      o_cmd_valid = 1'b0;
      o_cmd       = CMD_NOP;
      o_cmd_bg    = '0;
      o_cmd_bank  = '0;
      o_cmd_addr  = '0;
      case (r_state)
         S_ACT0, S_ACT1: begin
            o_cmd_valid = 1'b1;
            o_cmd       = (r_state == S_ACT0) ? CMD_ACT0 : CMD_ACT1;
            o_cmd_bg    = r_req.bg;
            o_cmd_bank  = r_req.bank;
            o_cmd_addr  = r_req.row;
         end
         S_COL0, S_COL1: begin
            o_cmd_valid = 1'b1;
            if (r_state == S_COL0) o_cmd = r_req.op ? CMD_WR0 : CMD_RD0;
            else                   o_cmd = r_req.op ? CMD_WR1 : CMD_RD1;
            o_cmd_bg    = r_req.bg;
            o_cmd_bank  = r_req.bank;
            o_cmd_addr  = {6'b0, r_req.col};
         end
         S_PRE: begin
            o_cmd_valid = 1'b1;
            o_cmd       = CMD_PRE;
            o_cmd_bg    = w_pre_bg;
            o_cmd_bank  = w_pre_bank;
         end
         S_REF: begin
            o_cmd_valid = 1'b1;
            o_cmd       = CMD_REF;
         end
         default: ;
      endcase
   end

   ddr5_timer #(
      .WIDTH     (CW),
      .RESET_VAL ('0)
   ) u_wait_timer (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_load     (w_wait_load),
      .i_load_val (w_wait_val),
      .o_expired  (w_wait_exp)
   );

   ddr5_timer #(
      .WIDTH     (CW),
      .RESET_VAL (LD_REFI)
   ) u_refi_timer (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_load     (w_refi_exp),
      .i_load_val (LD_REFI),
      .o_expired  (w_refi_exp)
   );

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench: default-timing DUT (a_*) and a short-refresh DUT (b_*, T_REFI=100, T_RFC=50).
// Open-page sequence is exercised when OPEN_PAGE_EN is defined.
module tb_ddr5_cmd_sequencer;

   localparam logic [3:0] NOP = 4'd0, ACT0 = 4'd1, ACT1 = 4'd2, RD0 = 4'd3, RD1 = 4'd4;
   localparam logic [3:0] WR0 = 4'd5, WR1 = 4'd6, PRE = 4'd7, REF = 4'd8;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   a_nvalid = 0;

   logic a_rst_n, a_valid, a_op, a_ready, a_cmd_valid, a_done, a_ovr;
   logic [2:0] a_bg, a_cmd_bg;
   logic [1:0] a_bank, a_cmd_bank;
   logic [15:0] a_row, a_cmd_addr;
   logic [9:0] a_col;
   logic [3:0] a_cmd;

   logic b_rst_n, b_valid, b_op, b_ready, b_cmd_valid, b_done, b_ovr;
   logic [2:0] b_bg, b_cmd_bg;
   logic [1:0] b_bank, b_cmd_bank;
   logic [15:0] b_row, b_cmd_addr;
   logic [9:0] b_col;
   logic [3:0] b_cmd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (a_cmd_valid) a_nvalid <= a_nvalid + 1;

   ddr5_cmd_sequencer u_dut_a (
      .i_clock(clk), .i_reset_n(a_rst_n), .i_req_valid(a_valid), .o_req_ready(a_ready),
      .i_req_op(a_op), .i_req_bg(a_bg), .i_req_bank(a_bank), .i_req_row(a_row),
      .i_req_col(a_col), .o_cmd_valid(a_cmd_valid), .o_cmd(a_cmd), .o_cmd_bg(a_cmd_bg),
      .o_cmd_bank(a_cmd_bank), .o_cmd_addr(a_cmd_addr), .o_done(a_done),
      .o_ref_overrun(a_ovr)
   );

   ddr5_cmd_sequencer #(.T_REFI(100), .T_RFC(50)) u_dut_b (
      .i_clock(clk), .i_reset_n(b_rst_n), .i_req_valid(b_valid), .o_req_ready(b_ready),
      .i_req_op(b_op), .i_req_bg(b_bg), .i_req_bank(b_bank), .i_req_row(b_row),
      .i_req_col(b_col), .o_cmd_valid(b_cmd_valid), .o_cmd(b_cmd), .o_cmd_bg(b_cmd_bg),
      .o_cmd_bank(b_cmd_bank), .o_cmd_addr(b_cmd_addr), .o_done(b_done),
      .o_ref_overrun(b_ovr)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic op, input logic [2:0] bg, input logic [1:0] bank,
                        input logic [15:0] row, input logic [9:0] col);
      a_op = op; a_bg = bg; a_bank = bank; a_row = row; a_col = col;
   endtask

   task automatic wait_cmd(input bit sel, input logic [3:0] c, input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!sel && a_cmd_valid && a_cmd == c) begin at = cyc; break; end
         if (sel && b_cmd_valid && b_cmd == c) begin at = cyc; break; end
      end
   endtask

   task automatic wait_ready_a(input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (a_ready) begin at = cyc; break; end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, at, base, n0, hi;
      a_rst_n = 1'b0; a_valid = 1'b0; set_a(1'b0, 3'd0, 2'd0, 16'h0, 10'h0);
      b_rst_n = 1'b0; b_valid = 1'b0;
      b_op = 1'b0; b_bg = '0; b_bank = '0; b_row = '0; b_col = '0;
      repeat (3) @(negedge clk);
      a_rst_n = 1'b1;

      // Reset state
      check("rst_cmd_valid", a_cmd_valid, 0);
      check("rst_cmd", a_cmd, NOP);
      check("rst_addr", a_cmd_addr, 0);
      check("rst_ready", a_ready, 1);
      check("rst_done", a_done, 0);
      check("rst_overrun", a_ovr, 0);

      // Read bg=2 bank=1 row=0x1234 col=0x40
      set_a(1'b0, 3'd2, 2'd1, 16'h1234, 10'h040);
      a_valid = 1'b1;
      acc = cyc;
      @(negedge clk);
      a_valid = 1'b0;
      check("t1_act0_cmd", a_cmd, ACT0);
      check("t1_act0_valid", a_cmd_valid, 1);
      check("t1_act0_bg", a_cmd_bg, 2);
      check("t1_act0_bank", a_cmd_bank, 1);
      check("t1_act0_row", a_cmd_addr, 16'h1234);
      check("t1_ready_busy", a_ready, 0);
      @(negedge clk);
      check("t1_act1_cmd", a_cmd, ACT1);
      check("t1_act1_row", a_cmd_addr, 16'h1234);
      wait_cmd(1'b0, RD0, 200, at);
      check("t1_rd0_cycle", at - acc, 40);
      check("t1_rd0_col", a_cmd_addr, 16'h0040);
      @(negedge clk);
      check("t1_rd1_cmd", a_cmd, RD1);
      check("t1_rd1_done", a_done, 1);
      @(negedge clk);
      check("t1_done_pulse", a_done, 0);
      check("t1_nop_idle_bus", a_cmd_valid, 0);

`ifdef OPEN_PAGE_EN
      // Open page: hit skips ACT, miss precharges the old bank first
      wait_ready_a(200, at);
      check("t6_idle_cycle", at - acc, 88);
      set_a(1'b0, 3'd2, 2'd1, 16'h1234, 10'h080);
      a_valid = 1'b1;
      acc = cyc;
      @(negedge clk);
      a_valid = 1'b0;
      check("t6_hit_rd0", a_cmd, RD0);
      check("t6_hit_col", a_cmd_addr, 16'h0080);
      wait_ready_a(200, at);
      check("t6_hit_idle_cycle", at - acc, 49);
      set_a(1'b0, 3'd2, 2'd1, 16'h5678, 10'h010);
      a_valid = 1'b1;
      acc = cyc;
      @(negedge clk);
      a_valid = 1'b0;
      check("t6_miss_pre", a_cmd, PRE);
      check("t6_miss_pre_bg", a_cmd_bg, 2);
      wait_cmd(1'b0, ACT0, 100, at);
      check("t6_miss_act0_cycle", at - acc, 40);
      check("t6_miss_act0_row", a_cmd_addr, 16'h5678);
`else
      wait_cmd(1'b0, PRE, 200, at);
      check("t1_pre_cycle", at - acc, 88);
      check("t1_pre_bg", a_cmd_bg, 2);
      check("t1_pre_bank", a_cmd_bank, 1);
      check("t1_pre_addr", a_cmd_addr, 0);
      wait_ready_a(200, at);
      check("t1_idle_cycle", at - acc, 127);

      // Write to the same address, then a queued read behind it
      set_a(1'b1, 3'd2, 2'd1, 16'h1234, 10'h040);
      a_valid = 1'b1;
      acc = cyc;
      @(negedge clk);
      a_valid = 1'b0;
      check("t2_act0_cmd", a_cmd, ACT0);
      wait_cmd(1'b0, WR0, 200, at);
      check("t2_wr0_cycle", at - acc, 40);
      check("t2_wr0_col", a_cmd_addr, 16'h0040);
      @(negedge clk);
      check("t2_wr1_cmd", a_cmd, WR1);
      check("t2_wr1_done", a_done, 1);
      set_a(1'b0, 3'd3, 2'd0, 16'hBEEF, 10'h3FF);
      a_valid = 1'b1;
      wait_cmd(1'b0, PRE, 300, at);
      check("t2_pre_cycle", at - acc, 158);
      n0 = at;
      wait_cmd(1'b0, ACT0, 100, at);
      a_valid = 1'b0;
      check("t2_next_act0_gap", at - n0, 40);
      check("t2_next_act0_bg", a_cmd_bg, 3);
      check("t2_next_act0_row", a_cmd_addr, 16'hBEEF);
`endif

      // Reset while waiting for tRCD
      repeat (10) @(negedge clk);
      check("t5_in_wait_ready", a_ready, 0);
      check("t5_in_wait_valid", a_cmd_valid, 0);
      a_rst_n = 1'b0;
      @(negedge clk);
      check("t5_rst_cmd_valid", a_cmd_valid, 0);
      check("t5_rst_ready", a_ready, 1);
      a_rst_n = 1'b1;
      n0 = a_nvalid;
      repeat (60) @(negedge clk);
      check("t5_no_cmd_after_abort", a_nvalid - n0, 0);

      // Refresh priority and overrun on the short-refresh instance
      b_rst_n = 1'b1;
      base = cyc;
      check("b_rst_ready", b_ready, 1);
      check("b_rst_overrun", b_ovr, 0);
      while (cyc < base + 100) @(negedge clk);
      check("t3_ready_when_pending", b_ready, 0);
      b_op = 1'b1; b_bg = 3'd1; b_bank = 2'd3; b_row = 16'h0F0F; b_col = 10'h001;
      b_valid = 1'b1;
      @(negedge clk);
      check("t3_ref_first", b_cmd, REF);
      check("t3_ref_addr", b_cmd_addr, 0);
      hi = 0;
      for (int i = 0; i < 49; i++) begin
         @(negedge clk);
         if (b_ready) hi++;
      end
      check("t3_ready_low_in_rfc", hi, 0);
      @(negedge clk);
      check("t3_ready_after_rfc", b_ready, 1);
      @(negedge clk);
      b_valid = 1'b0;
      check("t3_act0_after_ref", b_cmd, ACT0);
      check("t4_overrun_clear", b_ovr, 0);
      wait_cmd(1'b1, WR0, 100, at);
      check("t4_wr0_cycle", at - base, 191);
      while (cyc < base + 299) @(negedge clk);
      check("t4_overrun_before", b_ovr, 0);
      @(negedge clk);
      check("t4_overrun_set", b_ovr, 1);
      wait_cmd(1'b1, REF, 100, at);
      check("t4_ref_after_write", at - base, 349);
      repeat (50) @(negedge clk);
      check("t4_overrun_sticky", b_ovr, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
